// File: rtl/vc_input_stage.sv
// Virtual-channel input stage: pops words from the main FIFO and steers each one
// into a VC0/VC1 show-ahead FIFO by its class bit, with per-VC status and underflow flags.
module vc_input_stage #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  empty_main,
  output logic                  pop_main,
  output logic [DATA_WIDTH-1:0] data_out_VC0,
  output logic [DATA_WIDTH-1:0] data_out_VC1,
  output logic                  empty_fifo_VC0,
  output logic                  empty_fifo_VC1,
  input  logic                  pop_VC0_fifo,
  input  logic                  pop_VC1_fifo,
  output logic                  almost_full_VC0,
  output logic                  almost_full_VC1,
  output logic                  almost_empty_VC0,
  output logic                  almost_empty_VC1,
  output logic                  error_VC0,
  output logic                  error_VC1
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(AF_THRESH);
  localparam logic [PTR_W:0] AE_C    = (PTR_W+1)'(AE_THRESH);

  logic                  target;
  logic [1:0]            pop_req;
  logic [PTR_W:0]        count_reg [2];
  logic [DATA_WIDTH-1:0] head      [2];
  logic [1:0]            empty_w;
  logic [1:0]            af_w;
  logic [1:0]            ae_w;
  logic [1:0]            err_reg;

  assign target  = data_in[4];
  assign pop_req = {pop_VC1_fifo, pop_VC0_fifo};

  // Full check uses the registered count only, so a same-cycle pop never frees a slot early.
  assign pop_main = !reset && !empty_main && (count_reg[target] < DEPTH_C);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0]      wr_ptr_reg;
      logic [PTR_W-1:0]      rd_ptr_reg;
      logic                  push_w;
      logic                  pop_w;

      assign push_w = pop_main && (target == 1'(gi));
      assign pop_w  = pop_req[gi] && (count_reg[gi] != '0);

      always_ff @(posedge clk) begin
        if (push_w) begin
          mem[wr_ptr_reg] <= data_in;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg    <= '0;
          rd_ptr_reg    <= '0;
          count_reg[gi] <= '0;
          err_reg[gi]   <= 1'b0;
        end else begin
          if (push_w) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop_w) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({push_w, pop_w})
            2'b10:   count_reg[gi] <= count_reg[gi] + 1'b1;
            2'b01:   count_reg[gi] <= count_reg[gi] - 1'b1;
            default: count_reg[gi] <= count_reg[gi];
          endcase
          // Underflow is sticky until the next reset.
          if (pop_req[gi] && (count_reg[gi] == '0)) begin
            err_reg[gi] <= 1'b1;
          end
        end
      end

      assign empty_w[gi] = (count_reg[gi] == '0);
      assign af_w[gi]    = (count_reg[gi] >= AF_C);
      assign ae_w[gi]    = (count_reg[gi] <= AE_C);
      assign head[gi]    = empty_w[gi] ? '0 : mem[rd_ptr_reg];
    end
  endgenerate

  assign data_out_VC0     = head[0];
  assign data_out_VC1     = head[1];
  assign empty_fifo_VC0   = empty_w[0];
  assign empty_fifo_VC1   = empty_w[1];
  assign almost_full_VC0  = af_w[0];
  assign almost_full_VC1  = af_w[1];
  assign almost_empty_VC0 = ae_w[0];
  assign almost_empty_VC1 = ae_w[1];
  assign error_VC0        = err_reg[0];
  assign error_VC1        = err_reg[1];

endmodule

// File: tb/tb_vc_input_stage.sv
// Directed bench for vc_input_stage: routing, full stall, wrap, simultaneous
// push/pop, sticky underflow and mid-operation reset.
module tb_vc_input_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] data_in;
  logic       empty_main;
  logic       pop_main;
  logic [5:0] data_out_VC0, data_out_VC1;
  logic       empty_fifo_VC0, empty_fifo_VC1;
  logic       pop_VC0_fifo, pop_VC1_fifo;
  logic       almost_full_VC0, almost_full_VC1;
  logic       almost_empty_VC0, almost_empty_VC1;
  logic       error_VC0, error_VC1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vc_input_stage dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .empty_main       (empty_main),
    .pop_main         (pop_main),
    .data_out_VC0     (data_out_VC0),
    .data_out_VC1     (data_out_VC1),
    .empty_fifo_VC0   (empty_fifo_VC0),
    .empty_fifo_VC1   (empty_fifo_VC1),
    .pop_VC0_fifo     (pop_VC0_fifo),
    .pop_VC1_fifo     (pop_VC1_fifo),
    .almost_full_VC0  (almost_full_VC0),
    .almost_full_VC1  (almost_full_VC1),
    .almost_empty_VC0 (almost_empty_VC0),
    .almost_empty_VC1 (almost_empty_VC1),
    .error_VC0        (error_VC0),
    .error_VC1        (error_VC1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [5:0] w);
    data_in    = w;
    empty_main = 1'b0;
    tick();
    empty_main = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    empty_main   = 1'b0;
    data_in      = 6'b010110;
    pop_VC0_fifo = 1'b0;
    pop_VC1_fifo = 1'b0;

    // Reset held two cycles with main non-empty
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_pop_main", {7'd0, pop_main}, 8'd0);
    end
    chk("rst_empty0", {7'd0, empty_fifo_VC0}, 8'd1);
    chk("rst_empty1", {7'd0, empty_fifo_VC1}, 8'd1);
    chk("rst_dout0", {2'd0, data_out_VC0}, 8'd0);
    chk("rst_dout1", {2'd0, data_out_VC1}, 8'd0);
    chk("rst_err0", {7'd0, error_VC0}, 8'd0);
    chk("rst_err1", {7'd0, error_VC1}, 8'd0);
    chk("rst_ae0", {7'd0, almost_empty_VC0}, 8'd1);
    chk("rst_af0", {7'd0, almost_full_VC0}, 8'd0);

    // Routing by bit 4
    reset   = 1'b0;
    data_in = 6'b100101;
    settle();
    chk("route_pop_main_a", {7'd0, pop_main}, 8'd1);
    tick();
    chk("route_vc0_visible", {2'd0, data_out_VC0}, 8'h25);
    data_in = 6'b010110;
    settle();
    chk("route_pop_main_b", {7'd0, pop_main}, 8'd1);
    tick();
    empty_main = 1'b1;
    chk("route_dout0", {2'd0, data_out_VC0}, 8'h25);
    chk("route_dout1", {2'd0, data_out_VC1}, 8'h16);
    chk("route_empty0", {7'd0, empty_fifo_VC0}, 8'd0);
    chk("route_empty1", {7'd0, empty_fifo_VC1}, 8'd0);

    // Drain both
    pop_VC0_fifo = 1'b1;
    pop_VC1_fifo = 1'b1;
    tick();
    pop_VC0_fifo = 1'b0;
    pop_VC1_fifo = 1'b0;
    chk("drain_empty0", {7'd0, empty_fifo_VC0}, 8'd1);
    chk("drain_empty1", {7'd0, empty_fifo_VC1}, 8'd1);

    // Fill VC0 to full with words 1..4, thresholds along the way
    for (int i = 1; i <= 4; i++) begin
      data_in    = 6'(i);
      empty_main = 1'b0;
      settle();
      chk("fill_pop_main", {7'd0, pop_main}, 8'd1);
      tick();
      chk("fill_af0", {7'd0, almost_full_VC0}, (i >= 3) ? 8'd1 : 8'd0);
      chk("fill_ae0", {7'd0, almost_empty_VC0}, (i <= 1) ? 8'd1 : 8'd0);
    end
    data_in = 6'b000101;
    settle();
    chk("full_stall", {7'd0, pop_main}, 8'd0);
    tick();
    chk("full_head", {2'd0, data_out_VC0}, 8'h01);
    pop_VC0_fifo = 1'b1;
    settle();
    chk("full_stall_with_pop", {7'd0, pop_main}, 8'd0);
    tick();
    pop_VC0_fifo = 1'b0;
    settle();
    chk("after_pop_accept", {7'd0, pop_main}, 8'd1);
    chk("after_pop_head", {2'd0, data_out_VC0}, 8'h02);
    tick();
    empty_main = 1'b1;
    chk("refull_af0", {7'd0, almost_full_VC0}, 8'd1);
    // Word 5 sits in the wrapped slot 0
    for (int i = 2; i <= 5; i++) begin
      chk("wrap_head", {2'd0, data_out_VC0}, 8'(i));
      pop_VC0_fifo = 1'b1;
      tick();
      pop_VC0_fifo = 1'b0;
    end
    chk("wrap_empty0", {7'd0, empty_fifo_VC0}, 8'd1);

    // Simultaneous push and pop at count 2
    push(6'h0A);
    push(6'h0B);
    data_in      = 6'h0C;
    empty_main   = 1'b0;
    pop_VC0_fifo = 1'b1;
    tick();
    empty_main = 1'b1;
    pop_VC0_fifo = 1'b0;
    chk("pp_head", {2'd0, data_out_VC0}, 8'h0B);
    chk("pp_ae0", {7'd0, almost_empty_VC0}, 8'd0);
    chk("pp_af0", {7'd0, almost_full_VC0}, 8'd0);
    pop_VC0_fifo = 1'b1;
    tick();
    chk("pp_head2", {2'd0, data_out_VC0}, 8'h0C);
    chk("pp_ae0_cnt1", {7'd0, almost_empty_VC0}, 8'd1);
    tick();
    pop_VC0_fifo = 1'b0;
    chk("pp_empty0", {7'd0, empty_fifo_VC0}, 8'd1);

    // Underflow on VC1
    pop_VC1_fifo = 1'b1;
    settle();
    chk("uf_err_before", {7'd0, error_VC1}, 8'd0);
    tick();
    pop_VC1_fifo = 1'b0;
    chk("uf_err1", {7'd0, error_VC1}, 8'd1);
    chk("uf_err0", {7'd0, error_VC0}, 8'd0);
    chk("uf_empty1", {7'd0, empty_fifo_VC1}, 8'd1);
    tick();
    tick();
    chk("uf_sticky", {7'd0, error_VC1}, 8'd1);
    push(6'h11);
    chk("uf_state_ok", {2'd0, data_out_VC1}, 8'h11);
    chk("uf_ae1", {7'd0, almost_empty_VC1}, 8'd1);

    // Mid-operation reset: VC0 = 3 words, VC1 = 2 words
    push(6'h01);
    push(6'h02);
    push(6'h03);
    push(6'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_empty0", {7'd0, empty_fifo_VC0}, 8'd1);
    chk("mr_empty1", {7'd0, empty_fifo_VC1}, 8'd1);
    chk("mr_dout0", {2'd0, data_out_VC0}, 8'd0);
    chk("mr_dout1", {2'd0, data_out_VC1}, 8'd0);
    chk("mr_ae0", {7'd0, almost_empty_VC0}, 8'd1);
    chk("mr_ae1", {7'd0, almost_empty_VC1}, 8'd1);
    chk("mr_err1", {7'd0, error_VC1}, 8'd0);
    push(6'h07);
    chk("mr_first_push", {2'd0, data_out_VC0}, 8'h07);
    chk("mr_vc1_untouched", {7'd0, empty_fifo_VC1}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
